pipe_hazard_unit: RTL

//  Parametrised hazard/forwarding controller for the in-order pipeline; replaces ad-hoc stall/Forward wiring in the CPU top.

---
 rtl/pipe_hazard_unit_pkg.sv | 19 +
 rtl/pipe_hazard_unit_match.sv | 46 ++++
 rtl/pipe_hazard_unit.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_unit_pkg.sv
// Shared definitions for the pipeline hazard/forwarding controller.
package pipe_hazard_unit_pkg;

  typedef enum logic [1:0] {
    USE_NONE = 2'd0,
    USE_ID   = 2'd1,
    USE_EX   = 2'd2,
    USE_MEM  = 2'd3
  } use_e;

  localparam int SEL_RF   = 0;
  localparam int N_MATCH  = 5;
  localparam int M_ID_RS  = 0;
  localparam int M_ID_RT  = 1;
  localparam int M_EX_RS  = 2;
  localparam int M_EX_RT  = 3;
  localparam int M_MEM_RT = 4;

endpackage

// File: rtl/pipe_hazard_unit_match.sv
// Priority matcher: youngest in-flight writer of a source register.
module pipe_hazard_unit_match
  import pipe_hazard_unit_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int DEPTH    = 3,
  parameter int ALU_RDY  = 1,
  parameter int LOAD_RDY = 2,
  parameter int SELW     = 2
) (
  input  logic [REG_AW-1:0]       i_src,
  input  logic [SELW-1:0]         i_min_k,
  input  logic [1:0]              i_off,
  input  logic [DEPTH-1:0]        i_vld,
  input  logic [DEPTH-1:0]        i_wr,
  input  logic [DEPTH-1:0]        i_ld,
  input  logic [DEPTH*REG_AW-1:0] i_dst,
  output logic                    o_hit,
  output logic [SELW-1:0]         o_k,
  output logic                    o_rdy,
  output logic                    o_wait
);

  function automatic int rdy_idx(input logic ld);
    return ld ? LOAD_RDY : ALU_RDY;
  endfunction

  // Walk oldest to youngest so the youngest match is left standing.
  always_comb begin
    o_hit  = 1'b0;
    o_k    = '0;
    o_rdy  = 1'b0;
    o_wait = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (k >= int'(i_min_k) && i_vld[k] && i_wr[k] &&
          i_dst[k*REG_AW +: REG_AW] == i_src &&
          i_src != '0) begin
        o_hit  = 1'b1;
        o_k    = SELW'(k);
        o_rdy  = k >= rdy_idx(i_ld[k]);
        o_wait = (k + int'(i_off)) < rdy_idx(i_ld[k]);
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard/forwarding controller: writer scoreboard, stall and forward selects.
// Optional HAZARD_STATS_EN builds saturating stall/forward counters.
module pipe_hazard_unit
  import pipe_hazard_unit_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int DEPTH    = 3,
  parameter int ALU_RDY  = 1,
  parameter int LOAD_RDY = 2,
  parameter int CNT_W    = 32,
  localparam int SELW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic              id_kill,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [1:0]        id_rs_use,
  input  logic [1:0]        id_rt_use,
  input  logic              id_wr,
  input  logic [REG_AW-1:0] id_dst,
  input  logic              id_load,
  output logic              stall,
  output logic [SELW-1:0]   id_fwd_rs,
  output logic [SELW-1:0]   id_fwd_rt,
  output logic [SELW-1:0]   ex_fwd_rs,
  output logic [SELW-1:0]   ex_fwd_rt,
  output logic [SELW-1:0]   mem_fwd_rt,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  fwd_cnt
);

  logic [DEPTH-1:0]        r_sb_vld;
  logic [DEPTH-1:0]        r_sb_wr;
  logic [DEPTH-1:0]        r_sb_ld;
  logic [DEPTH*REG_AW-1:0] r_sb_dst;

  logic [REG_AW-1:0] r_ex_rs;
  logic [REG_AW-1:0] r_ex_rt;
  logic [1:0]        r_ex_rsu;
  logic [1:0]        r_ex_rtu;
  logic [REG_AW-1:0] r_mem_rt;
  logic [1:0]        r_mem_rtu;

  logic [REG_AW-1:0] w_src  [N_MATCH];
  logic [SELW-1:0]   w_min  [N_MATCH];
  logic [1:0]        w_off  [N_MATCH];
  logic              w_hit  [N_MATCH];
  logic [SELW-1:0]   w_k    [N_MATCH];
  logic              w_rdy  [N_MATCH];
  logic              w_wait [N_MATCH];
  logic              w_issue;
  logic              w_any_fwd;
  logic              w_unused;

  assign w_src[M_ID_RS]  = id_rs;
  assign w_src[M_ID_RT]  = id_rt;
  assign w_src[M_EX_RS]  = r_ex_rs;
  assign w_src[M_EX_RT]  = r_ex_rt;
  assign w_src[M_MEM_RT] = r_mem_rt;

  // EX skips itself (sb[0]); MEM skips EX and itself.
  assign w_min[M_ID_RS]  = '0;
  assign w_min[M_ID_RT]  = '0;
  assign w_min[M_EX_RS]  = SELW'(1);
  assign w_min[M_EX_RT]  = SELW'(1);
  assign w_min[M_MEM_RT] = SELW'(2);

  assign w_off[M_ID_RS]  = id_rs_use - 2'd1;
  assign w_off[M_ID_RT]  = id_rt_use - 2'd1;
  assign w_off[M_EX_RS]  = 2'd0;
  assign w_off[M_EX_RT]  = 2'd0;
  assign w_off[M_MEM_RT] = 2'd0;

  for (genvar g = 0; g < N_MATCH; g++) begin : g_match
    pipe_hazard_unit_match #(
      .REG_AW  (REG_AW),
      .DEPTH   (DEPTH),
      .ALU_RDY (ALU_RDY),
      .LOAD_RDY(LOAD_RDY),
      .SELW    (SELW)
    ) u_match (
      .i_src  (w_src[g]),
      .i_min_k(w_min[g]),
      .i_off  (w_off[g]),
      .i_vld  (r_sb_vld),
      .i_wr   (r_sb_wr),
      .i_ld   (r_sb_ld),
      .i_dst  (r_sb_dst),
      .o_hit  (w_hit[g]),
      .o_k    (w_k[g]),
      .o_rdy  (w_rdy[g]),
      .o_wait (w_wait[g])
    );
  end

  assign w_unused = ^{w_rdy[M_EX_RS], w_rdy[M_EX_RT],
                      w_rdy[M_MEM_RT], w_wait[M_EX_RS],
                      w_wait[M_EX_RT], w_wait[M_MEM_RT]};

  assign stall = id_valid &&
    ((id_rs_use != USE_NONE && w_hit[M_ID_RS] && w_wait[M_ID_RS]) ||
     (id_rt_use != USE_NONE && w_hit[M_ID_RT] && w_wait[M_ID_RT]));

  always_comb begin
    id_fwd_rs  = SELW'(SEL_RF);
    id_fwd_rt  = SELW'(SEL_RF);
    ex_fwd_rs  = SELW'(SEL_RF);
    ex_fwd_rt  = SELW'(SEL_RF);
    mem_fwd_rt = SELW'(SEL_RF);
    if (id_valid && id_rs_use == USE_ID &&
        w_hit[M_ID_RS] && w_rdy[M_ID_RS])
      id_fwd_rs = w_k[M_ID_RS] + SELW'(1);
    if (id_valid && id_rt_use == USE_ID &&
        w_hit[M_ID_RT] && w_rdy[M_ID_RT])
      id_fwd_rt = w_k[M_ID_RT] + SELW'(1);
    if (r_ex_rsu == USE_EX && w_hit[M_EX_RS])
      ex_fwd_rs = w_k[M_EX_RS] + SELW'(1);
    if (r_ex_rtu == USE_EX && w_hit[M_EX_RT])
      ex_fwd_rt = w_k[M_EX_RT] + SELW'(1);
    if (r_mem_rtu == USE_MEM && w_hit[M_MEM_RT])
      mem_fwd_rt = w_k[M_MEM_RT] + SELW'(1);
  end

  assign w_issue   = id_valid && !id_kill && !stall;
  assign w_any_fwd = |{id_fwd_rs, id_fwd_rt, ex_fwd_rs,
                       ex_fwd_rt, mem_fwd_rt};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sb_vld  <= '0;
      r_sb_wr   <= '0;
      r_sb_ld   <= '0;
      r_sb_dst  <= '0;
      r_ex_rs   <= '0;
      r_ex_rt   <= '0;
      r_ex_rsu  <= USE_NONE;
      r_ex_rtu  <= USE_NONE;
      r_mem_rt  <= '0;
      r_mem_rtu <= USE_NONE;
    end else begin
      r_sb_vld  <= {r_sb_vld[DEPTH-2:0], w_issue};
      r_sb_wr   <= {r_sb_wr[DEPTH-2:0], id_wr};
      r_sb_ld   <= {r_sb_ld[DEPTH-2:0], id_load};
      r_sb_dst  <= {r_sb_dst[(DEPTH-1)*REG_AW-1:0], id_dst};
      r_ex_rs   <= id_rs;
      r_ex_rt   <= id_rt;
      r_ex_rsu  <= w_issue ? id_rs_use : USE_NONE;
      r_ex_rtu  <= w_issue ? id_rt_use : USE_NONE;
      r_mem_rt  <= r_ex_rt;
      r_mem_rtu <= r_ex_rtu;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_fwd_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_fwd_cnt   <= '0;
    end else begin
      if (stall && !(&r_stall_cnt))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_any_fwd && !(&r_fwd_cnt))
        r_fwd_cnt <= r_fwd_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign fwd_cnt   = r_fwd_cnt;
`else
  logic w_unused_stats;
  assign w_unused_stats = w_any_fwd;
  assign stall_cnt      = '0;
  assign fwd_cnt        = '0;
`endif

endmodule
